// File: rtl/fast_intr_ctrl.sv
// ----------------------------------------------------------------------------
// fast_intr_ctrl
//   Fast-interrupt controller sitting in front of the core's irq vector.
//   Rising edges on peripheral lines are latched into pending bits, masked by a
//   software enable and presented on the fast-interrupt field of the core irq
//   vector. Taken interrupts are auto-cleared from the core's ack/id handshake.
//   Software access is a single-word OBI register slave.
//
//   Ports
//     clk_i       clock
//     rst_ni      asynchronous active-low reset
//     fast_src_i  level interrupt lines (already synchronous to clk_i)
//     fast_irq_o  pending & enable, to core irq_i[16 +: NUM_FAST]
//     irq_ack_i   core interrupt-taken pulse
//     irq_id_i    id of the taken interrupt, valid with irq_ack_i
//     reg_req_i   OBI register request  (req, we, be, addr, wdata)
//     reg_resp_o  OBI register response (gnt, rvalid, rdata)
//
//   Register map (word offset = addr[3:2], byte enables ignored)
//     0x0 PENDING  R: pending bits       W: write-1-to-clear
//     0x4 ENABLE   R/W: interrupt mask
//     0x8 SET      W: write-1-to-set      R: 0
//     0xC          R: 0                   W: ignored
// ----------------------------------------------------------------------------
package obi_pkg;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module fast_intr_ctrl #(
   parameter int unsigned NUM_FAST = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_FAST-1:0]  fast_src_i,
   output logic [NUM_FAST-1:0]  fast_irq_o,
   input  logic                 irq_ack_i,
   input  logic [4:0]           irq_id_i,
   input  obi_pkg::obi_req_t    reg_req_i,
   output obi_pkg::obi_resp_t   reg_resp_o
);

   localparam logic [1:0] OFF_PENDING = 2'd0;
   localparam logic [1:0] OFF_ENABLE  = 2'd1;
   localparam logic [1:0] OFF_SET     = 2'd2;

   logic [NUM_FAST-1:0] src_q_r;
   logic [NUM_FAST-1:0] pending_r;
   logic [NUM_FAST-1:0] enable_r;
   logic [NUM_FAST-1:0] fast_irq_r;
   logic                rvalid_r;
   logic [31:0]         rdata_r;

   logic                wr_s;
   logic                rd_s;
   logic [1:0]          reg_off_s;
   logic [NUM_FAST-1:0] wdata_s;
   logic [NUM_FAST-1:0] rise_s;
   logic [NUM_FAST-1:0] ack_s;
   logic [NUM_FAST-1:0] set_s;
   logic [NUM_FAST-1:0] clr_s;
   logic [NUM_FAST-1:0] pending_next_s;
   logic [NUM_FAST-1:0] enable_next_s;
   logic [31:0]         read_data_s;
   logic                unused_bits_s;

   // Byte enables and address bits outside the word offset play no role.
   assign unused_bits_s = ^{reg_req_i.be, reg_req_i.addr[31:4], reg_req_i.addr[1:0],
                            reg_req_i.wdata[31:NUM_FAST]};

   // Bus decode and per-source set/clear terms.
   always_comb begin
      wr_s      = reg_req_i.req & reg_req_i.we;
      rd_s      = reg_req_i.req & ~reg_req_i.we;
      reg_off_s = reg_req_i.addr[3:2];
      wdata_s   = reg_req_i.wdata[NUM_FAST-1:0];
      rise_s    = fast_src_i & ~src_q_r;
      for (int k = 0; k < NUM_FAST; k++) begin
         // Source k is irq id 16+k; ids outside the fast range never match.
         ack_s[k] = irq_ack_i & (irq_id_i == 5'(16 + k));
      end
      if (wr_s && (reg_off_s == OFF_SET)) begin
         set_s = rise_s | wdata_s;
      end else begin
         set_s = rise_s;
      end
      if (wr_s && (reg_off_s == OFF_PENDING)) begin
         clr_s = ack_s | wdata_s;
      end else begin
         clr_s = ack_s;
      end
      // Set dominates clear so an edge arriving with a W1C or ack is not lost.
      pending_next_s = set_s | (pending_r & ~clr_s);
      if (wr_s && (reg_off_s == OFF_ENABLE)) begin
         enable_next_s = wdata_s;
      end else begin
         enable_next_s = enable_r;
      end
   end

   // Read mux over the pre-update register state.
   always_comb begin
      read_data_s = 32'h0000_0000;
      case (reg_off_s)
         OFF_PENDING: read_data_s = {{(32-NUM_FAST){1'b0}}, pending_r};
         OFF_ENABLE:  read_data_s = {{(32-NUM_FAST){1'b0}}, enable_r};
         default:     read_data_s = 32'h0000_0000;
      endcase
   end

   // Interrupt state and the single-stage OBI response pipeline.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_q_r    <= {NUM_FAST{1'b0}};
         pending_r  <= {NUM_FAST{1'b0}};
         enable_r   <= {NUM_FAST{1'b0}};
         fast_irq_r <= {NUM_FAST{1'b0}};
         rvalid_r   <= 1'b0;
         rdata_r    <= 32'h0000_0000;
      end else begin
         src_q_r    <= fast_src_i;
         pending_r  <= pending_next_s;
         enable_r   <= enable_next_s;
         // Registered from next-state so the output equals pending_r & enable_r.
         fast_irq_r <= pending_next_s & enable_next_s;
         rvalid_r   <= reg_req_i.req;
         rdata_r    <= rd_s ? read_data_s : 32'h0000_0000;
      end
   end

   // Output drive; the grant is intentionally combinational (always ready).
   always_comb begin
      fast_irq_o        = fast_irq_r;
      reg_resp_o.gnt    = reg_req_i.req;
      reg_resp_o.rvalid = rvalid_r;
      reg_resp_o.rdata  = rdata_r;
   end

endmodule

// File: tb/tb_fast_intr_ctrl.sv
module tb_fast_intr_ctrl;
   localparam int NF = 15;

   logic               clk = 1'b0;
   logic               rst_ni = 1'b0;
   logic [NF-1:0]      fast_src = '0;
   logic [NF-1:0]      fast_irq;
   logic               irq_ack = 1'b0;
   logic [4:0]         irq_id = 5'd0;
   obi_pkg::obi_req_t  reg_req = '0;
   obi_pkg::obi_resp_t reg_resp;

   int checks = 0;
   int failures = 0;

   // reference model state
   bit [NF-1:0] m_pend, m_en, m_src_prev, m_irq;
   bit          m_rvalid;
   bit [31:0]   m_rdata;

   fast_intr_ctrl #(.NUM_FAST(NF)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .fast_src_i (fast_src),
      .fast_irq_o (fast_irq),
      .irq_ack_i  (irq_ack),
      .irq_id_i   (irq_id),
      .reg_req_i  (reg_req),
      .reg_resp_o (reg_resp)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pend = '0; m_en = '0; m_src_prev = '0; m_irq = '0;
      m_rvalid = 1'b0; m_rdata = 32'd0;
   endtask

   // One clock: compute expected next state from driven inputs, advance, commit.
   task automatic cycle();
      bit [NF-1:0] np, ne;
      bit [31:0]   rd;
      bit          nrv, wr;
      int          off;
      nrv = reg_req.req;
      wr  = reg_req.req && reg_req.we;
      off = int'(reg_req.addr[3:2]);
      rd  = 32'd0;
      if (reg_req.req && !reg_req.we) begin
         if (off == 0) rd = 32'(m_pend);
         else if (off == 1) rd = 32'(m_en);
         else rd = 32'd0;
      end
      np = m_pend;
      ne = m_en;
      for (int k = 0; k < NF; k++) begin
         bit s, c;
         s = (fast_src[k] && !m_src_prev[k]) || (wr && off == 2 && reg_req.wdata[k]);
         c = (wr && off == 0 && reg_req.wdata[k]) || (irq_ack && int'(irq_id) == 16 + k);
         if (s) np[k] = 1'b1;
         else if (c) np[k] = 1'b0;
      end
      if (wr && off == 1) ne = reg_req.wdata[NF-1:0];
      @(posedge clk);
      #1;
      m_pend = np; m_en = ne; m_src_prev = fast_src;
      m_irq = np & ne; m_rvalid = nrv; m_rdata = rd;
   endtask

   task automatic bus_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      reg_req.req = 1'b1; reg_req.we = we; reg_req.be = 4'hF;
      reg_req.addr = addr; reg_req.wdata = wdata;
      cycle();
      reg_req = '0;
   endtask

   task automatic test_reset();
      if (fast_irq !== 15'h0) begin failures++; $display("FAIL rst_irq got=%h exp=0", fast_irq); end
      checks++;
      if (reg_resp.rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", reg_resp.rvalid); end
      checks++;
      if (reg_resp.rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", reg_resp.rdata); end
      checks++;
      bus_op(1'b0, 32'h0, 32'h0);
      if (reg_resp.rdata !== 32'h0 || reg_resp.rvalid !== 1'b1) begin
         failures++; $display("FAIL rst_pending got=%h/%b exp=0/1", reg_resp.rdata, reg_resp.rvalid);
      end
      checks++;
   endtask

   task automatic test_edge();
      bus_op(1'b1, 32'h4, 32'h7FFF);
      fast_src[3] = 1'b1;
      cycle();
      if (fast_irq !== 15'h0008) begin failures++; $display("FAIL edge_irq got=%h exp=0008", fast_irq); end
      checks++;
      bus_op(1'b0, 32'h0, 32'h0);
      if (reg_resp.rdata !== 32'h8) begin failures++; $display("FAIL edge_pending got=%h exp=8", reg_resp.rdata); end
      checks++;
      fast_src = '0;
   endtask

   task automatic test_ack();
      irq_ack = 1'b1; irq_id = 5'd19;
      cycle();
      irq_ack = 1'b0;
      if (fast_irq !== 15'h0) begin failures++; $display("FAIL ack_irq got=%h exp=0", fast_irq); end
      checks++;
      bus_op(1'b0, 32'h0, 32'h0);
      if (reg_resp.rdata !== 32'h0) begin failures++; $display("FAIL ack_pending got=%h exp=0", reg_resp.rdata); end
      checks++;
      bus_op(1'b1, 32'h8, 32'h8);
      irq_ack = 1'b1; irq_id = 5'd11;
      cycle();
      irq_ack = 1'b0;
      if (fast_irq !== 15'h0008) begin failures++; $display("FAIL ack_bad_id got=%h exp=0008", fast_irq); end
      checks++;
      bus_op(1'b1, 32'h0, 32'h8);
   endtask

   task automatic test_collision();
      fast_src[5] = 1'b1;
      reg_req.req = 1'b1; reg_req.we = 1'b1; reg_req.be = 4'hF;
      reg_req.addr = 32'h0; reg_req.wdata = 32'h20;
      cycle();
      reg_req = '0;
      if (fast_irq !== 15'h0020) begin failures++; $display("FAIL set_vs_w1c got=%h exp=0020", fast_irq); end
      checks++;
      fast_src[5] = 1'b0;
      bus_op(1'b1, 32'h0, 32'h20);
      if (fast_irq !== 15'h0) begin failures++; $display("FAIL w1c_clear got=%h exp=0", fast_irq); end
      checks++;
      fast_src[5] = 1'b1;
      irq_ack = 1'b1; irq_id = 5'd21;
      reg_req.req = 1'b1; reg_req.we = 1'b1; reg_req.be = 4'hF;
      reg_req.addr = 32'h0; reg_req.wdata = 32'h20;
      cycle();
      reg_req = '0; irq_ack = 1'b0;
      if (fast_irq !== 15'h0020) begin failures++; $display("FAIL set_vs_ack got=%h exp=0020", fast_irq); end
      checks++;
      fast_src = '0;
      bus_op(1'b1, 32'h0, 32'h20);
   endtask

   task automatic test_enable_mask();
      bus_op(1'b1, 32'h4, 32'h0);
      fast_src[0] = 1'b1;
      cycle();
      fast_src[0] = 1'b0;
      if (fast_irq !== 15'h0) begin failures++; $display("FAIL mask_irq got=%h exp=0", fast_irq); end
      checks++;
      bus_op(1'b0, 32'h0, 32'h0);
      if (reg_resp.rdata !== 32'h1) begin failures++; $display("FAIL mask_pending got=%h exp=1", reg_resp.rdata); end
      checks++;
      bus_op(1'b1, 32'h4, 32'h1);
      if (fast_irq !== 15'h0001) begin failures++; $display("FAIL unmask_irq got=%h exp=0001", fast_irq); end
      checks++;
      bus_op(1'b1, 32'h4, 32'h0);
      if (fast_irq !== 15'h0) begin failures++; $display("FAIL remask_irq got=%h exp=0", fast_irq); end
      checks++;
      bus_op(1'b1, 32'h0, 32'h1);
   endtask

   task automatic test_back_to_back();
      bus_op(1'b1, 32'h8, 32'h4001);
      if (reg_resp.rvalid !== 1'b1 || reg_resp.rdata !== 32'h0) begin
         failures++; $display("FAIL write_rvalid got=%b/%h exp=1/0", reg_resp.rvalid, reg_resp.rdata);
      end
      checks++;
      bus_op(1'b0, 32'h0, 32'h0);
      if (reg_resp.rdata !== 32'h4001) begin failures++; $display("FAIL set_reg got=%h exp=4001", reg_resp.rdata); end
      checks++;
      bus_op(1'b0, 32'hC, 32'h0);
      if (reg_resp.rdata !== 32'h0) begin failures++; $display("FAIL rsvd_read got=%h exp=0", reg_resp.rdata); end
      checks++;
      bus_op(1'b1, 32'h4, 32'hFFFF_FFFF);
      reg_req.req = 1'b1; reg_req.we = 1'b0; reg_req.be = 4'hF; reg_req.addr = 32'h0;
      cycle();
      if (reg_resp.rvalid !== 1'b1 || reg_resp.rdata !== 32'h4001) begin
         failures++; $display("FAIL b2b_first got=%b/%h exp=1/4001", reg_resp.rvalid, reg_resp.rdata);
      end
      checks++;
      reg_req.addr = 32'h4;
      cycle();
      reg_req = '0;
      if (reg_resp.rvalid !== 1'b1 || reg_resp.rdata !== 32'h7FFF) begin
         failures++; $display("FAIL b2b_second got=%b/%h exp=1/7fff", reg_resp.rvalid, reg_resp.rdata);
      end
      checks++;
      cycle();
      if (reg_resp.rvalid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", reg_resp.rvalid); end
      checks++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         fast_src = NF'($urandom);
         irq_ack  = ($urandom_range(0, 2) == 0);
         irq_id   = 5'($urandom_range(10, 31));
         reg_req.req   = $urandom_range(0, 1) == 1;
         reg_req.we    = $urandom_range(0, 1) == 1;
         reg_req.be    = 4'($urandom);
         reg_req.addr  = {26'($urandom), 2'($urandom_range(0, 3)), 2'($urandom)};
         reg_req.wdata = $urandom;
         #1;
         if (reg_resp.gnt !== reg_req.req) begin
            failures++; $display("FAIL rnd_gnt i=%0d got=%b exp=%b", i, reg_resp.gnt, reg_req.req);
         end
         checks++;
         cycle();
         if (fast_irq !== m_irq) begin
            failures++; $display("FAIL rnd_irq i=%0d got=%h exp=%h", i, fast_irq, m_irq);
         end
         checks++;
         if (reg_resp.rvalid !== m_rvalid || reg_resp.rdata !== m_rdata) begin
            failures++; $display("FAIL rnd_resp i=%0d got=%b/%h exp=%b/%h", i,
                                 reg_resp.rvalid, reg_resp.rdata, m_rvalid, m_rdata);
         end
         checks++;
      end
      reg_req = '0; irq_ack = 1'b0; fast_src = '0;
      cycle();
   endtask

   task automatic test_reset_mid();
      bus_op(1'b1, 32'h4, 32'h0);
      bus_op(1'b1, 32'h8, 32'h7FFF);
      bus_op(1'b0, 32'h0, 32'h0);
      if (reg_resp.rvalid !== 1'b1 || reg_resp.rdata !== 32'h7FFF) begin
         failures++; $display("FAIL pre_rst got=%b/%h exp=1/7fff", reg_resp.rvalid, reg_resp.rdata);
      end
      checks++;
      bus_op(1'b1, 32'h4, 32'h7FFF);
      reg_req.req = 1'b1; reg_req.we = 1'b0; reg_req.addr = 32'h0;
      cycle();
      reg_req = '0;
      fast_src = 15'h7FFF;
      rst_ni = 1'b0;
      #1;
      if (fast_irq !== 15'h0 || reg_resp.rvalid !== 1'b0 || reg_resp.rdata !== 32'h0) begin
         failures++; $display("FAIL async_rst got=%h/%b/%h exp=0/0/0", fast_irq, reg_resp.rvalid, reg_resp.rdata);
      end
      checks++;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst_ni = 1'b1;
      bus_op(1'b0, 32'h0, 32'h0);
      if (reg_resp.rdata !== 32'h0) begin failures++; $display("FAIL rel_first got=%h exp=0", reg_resp.rdata); end
      checks++;
      bus_op(1'b0, 32'h0, 32'h0);
      if (reg_resp.rdata !== 32'h7FFF || reg_resp.rdata !== m_rdata) begin
         failures++; $display("FAIL rel_pending got=%h exp=7fff", reg_resp.rdata);
      end
      checks++;
      bus_op(1'b1, 32'h4, 32'h7FFF);
      if (fast_irq !== 15'h7FFF) begin failures++; $display("FAIL rel_irq got=%h exp=7fff", fast_irq); end
      checks++;
   endtask

   initial begin
      model_reset();
      rst_ni = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_ni = 1'b1;
      test_reset();
      test_edge();
      test_ack();
      test_collision();
      test_enable_mask();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
